// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Bits per frame: start + data + optional parity + stop.
  function automatic int uart_frame_bits(int word_width, int parity_mode, int stop_bits);
    return 1 + word_width + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Write/locked handshake and serial line of the UART transmitter.
interface uart_tx_fsm_if #(
  parameter int word_width = 8
);
  logic                  write;
  logic [word_width-1:0] T_W;
  logic                  T_locked;
  logic                  T_done;
  logic                  TX;

  modport master (output write, T_W, input T_locked, T_done, TX);
  modport slave  (input write, T_W, output T_locked, T_done, TX);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: reloads on restart, tick while the count is zero.
module uart_baud_tick #(
  parameter int clk_reduction = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(clk_reduction);
  localparam logic [CW-1:0] RELOAD = CW'(clk_reduction - 1);

  logic [CW-1:0] cnt;

  // Holds at zero when nothing restarts it, so an idle transmitter stays quiet.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (restart)     cnt <= RELOAD;
    else if (cnt != '0)   cnt <= cnt - CW'(1);
  end

  assign tick = (cnt == '0);
endmodule

// File: rtl/uart_tx_fsm.sv
// Frame-accurate UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int clk_reduction = 16,
  parameter int word_width    = 8,
  parameter int parity_mode   = 0,
  parameter int stop_bits     = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fsm_if.slave      bus
);
  if (clk_reduction < 2) begin : g_bad_cr
    $error("uart_tx_fsm: clk_reduction must be >= 2");
  end
  if (word_width < 1) begin : g_bad_ww
    $error("uart_tx_fsm: word_width must be >= 1");
  end
  if (parity_mode < PARITY_NONE || parity_mode > PARITY_ODD) begin : g_bad_pm
    $error("uart_tx_fsm: parity_mode must be 0, 1 or 2");
  end
  if (stop_bits != 1 && stop_bits != 2) begin : g_bad_sb
    $error("uart_tx_fsm: stop_bits must be 1 or 2");
  end

  localparam int IW = (word_width > 1) ? $clog2(word_width) : 1;
  localparam logic [IW-1:0] DATA_LAST = IW'(word_width - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(stop_bits - 1);

  uart_tx_state_t        state_q, state_d;
  logic [word_width-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  lock_q, lock_d;
  logic                  done_q, done_d;
  logic                  restart, tick;

  uart_baud_tick #(.clk_reduction(clk_reduction)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      lock_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      lock_q  <= lock_d;
      done_q  <= done_d;
    end
  end

  // tx_d is the line level for the cycle after this edge, so TX comes straight off a flop.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    lock_d  = lock_q;
    done_d  = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.write) begin
          shift_d = bus.T_W;
          par_d   = (parity_mode == PARITY_ODD) ? ~^bus.T_W : ^bus.T_W;
          idx_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          lock_d  = 1'b1;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          restart = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          restart = 1'b1;
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (parity_mode != PARITY_NONE) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
            tx_d    = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          restart = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            lock_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IW'(1);
            restart = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        lock_d  = 1'b0;
      end
    endcase
  end

  assign bus.TX       = tx_q;
  assign bus.T_locked = lock_q;
  assign bus.T_done   = done_q;

  a_lock_vs_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) == !lock_q);
  a_idle_high: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> tx_q);
endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm across parity, stop-bit and minimum-size configurations.
module tb_uart_tx_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] wr;
  logic [7:0] tw;
  int         tests = 0;
  int         fails = 0;

  // Per-instance configuration: 0 none/1stop, 1 even, 2 odd, 3 none/2stop, 4 minimum size.
  int cr_a[5] = '{4, 4, 4, 4, 2};
  int ww_a[5] = '{8, 8, 8, 8, 1};
  int pm_a[5] = '{0, 1, 2, 0, 0};
  int sb_a[5] = '{1, 1, 1, 2, 1};

  bit   exp_q[$];
  logic obs[$];

  always #5 clk = ~clk;

  uart_tx_fsm_if #(.word_width(8)) b0();
  uart_tx_fsm_if #(.word_width(8)) b1();
  uart_tx_fsm_if #(.word_width(8)) b2();
  uart_tx_fsm_if #(.word_width(8)) b3();
  uart_tx_fsm_if #(.word_width(1)) b4();

  assign b0.write = wr[0]; assign b0.T_W = tw;
  assign b1.write = wr[1]; assign b1.T_W = tw;
  assign b2.write = wr[2]; assign b2.T_W = tw;
  assign b3.write = wr[3]; assign b3.T_W = tw;
  assign b4.write = wr[4]; assign b4.T_W = tw[0];

  uart_tx_fsm #(.clk_reduction(4), .word_width(8), .parity_mode(0), .stop_bits(1)) d0 (.clk(clk), .rst(rst), .bus(b0));
  uart_tx_fsm #(.clk_reduction(4), .word_width(8), .parity_mode(1), .stop_bits(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  uart_tx_fsm #(.clk_reduction(4), .word_width(8), .parity_mode(2), .stop_bits(1)) d2 (.clk(clk), .rst(rst), .bus(b2));
  uart_tx_fsm #(.clk_reduction(4), .word_width(8), .parity_mode(0), .stop_bits(2)) d3 (.clk(clk), .rst(rst), .bus(b3));
  uart_tx_fsm #(.clk_reduction(2), .word_width(1), .parity_mode(0), .stop_bits(1)) d4 (.clk(clk), .rst(rst), .bus(b4));

  function automatic logic tx_of(int k);
    case (k)
      0: return b0.TX; 1: return b1.TX; 2: return b2.TX; 3: return b3.TX; default: return b4.TX;
    endcase
  endfunction
  function automatic logic lk_of(int k);
    case (k)
      0: return b0.T_locked; 1: return b1.T_locked; 2: return b2.T_locked; 3: return b3.T_locked; default: return b4.T_locked;
    endcase
  endfunction
  function automatic logic dn_of(int k);
    case (k)
      0: return b0.T_done; 1: return b1.T_done; 2: return b2.T_done; 3: return b3.T_done; default: return b4.T_done;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Reference line image of one frame: every bit repeated for one bit period.
  task automatic build_exp(input int k, input logic [7:0] d);
    int  ones;
    bit  pbit;
    exp_q.delete();
    ones = 0;
    for (int b = 0; b < ww_a[k]; b++) if (d[b]) ones++;
    repeat (cr_a[k]) exp_q.push_back(1'b0);
    for (int b = 0; b < ww_a[k]; b++) repeat (cr_a[k]) exp_q.push_back(d[b]);
    if (pm_a[k] != 0) begin
      pbit = (pm_a[k] == 1) ? bit'(ones % 2) : bit'(1 - ones % 2);
      repeat (cr_a[k]) exp_q.push_back(pbit);
    end
    repeat (sb_a[k] * cr_a[k]) exp_q.push_back(1'b1);
  endtask

  // Sends one frame, records the line while T_locked is high, checks length, bits and T_done.
  task automatic do_frame(input int k, input logic [7:0] d, input int busy_at, input string nm);
    int n, errs, first_bad;
    build_exp(k, d);
    wr[k] = 1'b1; tw = d;
    step();
    wr[k] = 1'b0; tw = 8'($urandom);
    obs.delete();
    n = 0;
    while (lk_of(k) === 1'b1 && n < 300) begin
      obs.push_back(tx_of(k));
      if (n == busy_at) begin wr[k] = 1'b1; tw = 8'hFF; end
      else if (n == busy_at + 1) wr[k] = 1'b0;
      step();
      n++;
    end
    tests++;
    if (n !== exp_q.size()) begin
      fails++;
      $display("FAIL %s_locked_len: got %0d cycles, expected %0d", nm, n, exp_q.size());
    end
    errs = 0; first_bad = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= obs.size() || obs[i] !== logic'(exp_q[i])) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    tests++;
    if (errs != 0) begin
      fails++;
      $display("FAIL %s_tx_bits: %0d wrong samples (first at %0d), data=%h expected all correct", nm, errs, first_bad, d);
    end
    tests++;
    if (dn_of(k) !== 1'b1 || tx_of(k) !== 1'b1) begin
      fails++;
      $display("FAIL %s_done: T_done=%b TX=%b at frame end, expected 1 1", nm, dn_of(k), tx_of(k));
    end
    step();
    tests++;
    if (dn_of(k) !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: T_done=%b one cycle later, expected 0", nm, dn_of(k));
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (tx_of(k) !== 1'b1 || lk_of(k) !== 1'b0 || dn_of(k) !== 1'b0) begin
        fails++;
        $display("FAIL reset_%0d: TX/locked/done=%b%b%b, expected 100", k, tx_of(k), lk_of(k), dn_of(k));
      end
    end
  endtask

  task automatic test_basic();
    do_frame(0, 8'hA5, -1, "basic");
  endtask

  task automatic test_parity();
    do_frame(1, 8'h07, -1, "even07");
    tests++;
    if (obs.size() < 40 || obs[37] !== 1'b1) begin
      fails++; $display("FAIL even07_parity_bit: got %b, expected 1", (obs.size() < 40) ? 1'bx : obs[37]);
    end
    do_frame(2, 8'h07, -1, "odd07");
    tests++;
    if (obs.size() < 40 || obs[37] !== 1'b0) begin
      fails++; $display("FAIL odd07_parity_bit: got %b, expected 0", (obs.size() < 40) ? 1'bx : obs[37]);
    end
    do_frame(1, 8'hA5, -1, "evenA5");
    tests++;
    if (obs.size() < 40 || obs[37] !== 1'b0) begin
      fails++; $display("FAIL evenA5_parity_bit: got %b, expected 0", (obs.size() < 40) ? 1'bx : obs[37]);
    end
  endtask

  task automatic test_busy_ignore();
    int starts;
    do_frame(0, 8'h3C, 10, "busy");
    starts = 0;
    repeat (20) begin
      if (lk_of(0) !== 1'b0) starts++;
      step();
    end
    tests++;
    if (starts != 0) begin
      fails++; $display("FAIL busy_no_second_frame: locked for %0d cycles after T_done, expected 0", starts);
    end
  endtask

  task automatic test_back_to_back();
    logic txs[100], lks[100];
    int   errs, rise, n;
    build_exp(3, 8'h55);
    wr[3] = 1'b1; tw = 8'h55;
    step();
    for (int t = 0; t < 100; t++) begin
      txs[t] = tx_of(3); lks[t] = lk_of(3);
      step();
    end
    wr[3] = 1'b0;
    errs = 0;
    for (int t = 0; t < 100; t++) begin
      if ((t % 45) < 44) begin
        if (txs[t] !== logic'(exp_q[t % 45]) || lks[t] !== 1'b1) errs++;
      end else if (txs[t] !== 1'b1 || lks[t] !== 1'b0) errs++;
    end
    tests++;
    if (errs != 0) begin
      fails++; $display("FAIL b2b_pattern: %0d wrong samples over 100 cycles, expected 0", errs);
    end
    rise = -1;
    for (int t = 1; t < 100; t++) if (rise < 0 && lks[t-1] === 1'b0 && lks[t] === 1'b1) rise = t;
    tests++;
    if (rise != 45 || txs[45] !== 1'b0) begin
      fails++; $display("FAIL b2b_second_start: at cycle %0d (TX=%b), expected 45 (TX=0)", rise, txs[45]);
    end
    n = 0;
    while (lk_of(3) === 1'b1 && n < 100) begin step(); n++; end
    tests++;
    if (lk_of(3) !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: still locked after %0d cycles, expected idle", n);
    end
    step();
  endtask

  task automatic test_mid_reset();
    wr[0] = 1'b1; tw = 8'($urandom);
    step();
    wr[0] = 1'b0;
    repeat (16) step();
    rst = 1'b1;
    step();
    tests++;
    if (tx_of(0) !== 1'b1 || lk_of(0) !== 1'b0 || dn_of(0) !== 1'b0) begin
      fails++; $display("FAIL midrst_outputs: TX/locked/done=%b%b%b, expected 100", tx_of(0), lk_of(0), dn_of(0));
    end
    rst = 1'b0;
    step();
    tests++;
    if (dn_of(0) !== 1'b0 || lk_of(0) !== 1'b0) begin
      fails++; $display("FAIL midrst_no_done: done=%b locked=%b after reset, expected 0 0", dn_of(0), lk_of(0));
    end
    do_frame(0, 8'($urandom), -1, "post_rst");
  endtask

  task automatic test_min_size();
    logic [5:0] pat;
    do_frame(4, 8'h01, -1, "min1");
    pat = 'x;
    if (obs.size() == 6) pat = {obs[0], obs[1], obs[2], obs[3], obs[4], obs[5]};
    tests++;
    if (pat !== 6'b001111) begin
      fails++; $display("FAIL min1_pattern: got %b, expected 001111", pat);
    end
    do_frame(4, 8'h00, -1, "min0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_frame(int'($urandom_range(0, 3)), 8'($urandom), -1, "rand");
    end
  endtask

  initial begin
    rst = 1'b1; wr = '0; tw = '0;
    step(); step();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_min_size();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
